// File: rtl/ir_pkg.sv
// Shared defaults for the instruction register / return-address stack.
// Holds the opcode encodings and the decode classification type.
package ir_pkg;

   localparam int IR_IW    = 22;
   localparam int IR_OPW   = 12;
   localparam int IR_AW    = 10;
   localparam int IR_DEPTH = 8;

   localparam logic [IR_OPW-1:0] IR_BSR_OP   = 12'b011100000000;
   localparam logic [IR_IW-1:0]  IR_RET_CODE = 22'b0000011000000000000000;
   localparam logic [IR_IW-1:0]  IR_NOP_CODE = 22'b0;

   // Decode result of the incoming program-memory word
   typedef enum logic [1:0] {
      DEC_NONE = 2'd0,
      DEC_BSR  = 2'd1,
      DEC_RET  = 2'd2
   } dec_e;

endpackage

// File: rtl/ir_callstack_if.sv
// Pipeline-side signal bundle of the instruction register and call stack.
// HOLD is a stall: while high, nothing advances; FLUSH overrides it and injects a NOP.
interface ir_callstack_if #(
   parameter int IW    = 22,
   parameter int AW    = 10,
   parameter int DEPTH = 8
) ();

   localparam int DW = $clog2(DEPTH + 1);

   logic          HOLD;
   logic          FLUSH;
   logic [IW-1:0] PR_code;
   logic [AW-1:0] PC_in;
   logic          clr_err;

   logic [IW-1:0] IR_code;
   logic          bsr_det;
   logic          ret_det;
   logic [AW-1:0] ret_addr;
   logic [DW-1:0] stack_depth;
   logic          stack_full;
   logic          stack_empty;
   logic          stack_ovf;
   logic          stack_unf;

   modport master (
      output HOLD, FLUSH, PR_code, PC_in, clr_err,
      input  IR_code, bsr_det, ret_det, ret_addr, stack_depth,
      input  stack_full, stack_empty, stack_ovf, stack_unf
   );

   modport slave (
      input  HOLD, FLUSH, PR_code, PC_in, clr_err,
      output IR_code, bsr_det, ret_det, ret_addr, stack_depth,
      output stack_full, stack_empty, stack_ovf, stack_unf
   );

endinterface

// File: rtl/ir_callstack_ret_stack.sv
// LIFO of return addresses. Push is ignored when full and pop when empty;
// entries are written only on push and are never reset.
module ret_stack #(
   parameter  int AW    = 10,
   parameter  int DEPTH = 8,
   localparam int DW    = $clog2(DEPTH + 1),
   localparam int IXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] top,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty
);

   logic [AW-1:0]  mem [DEPTH];
   logic [DW-1:0]  sp;
   logic [IXW-1:0] wr_ix;
   logic [IXW-1:0] rd_ix;

   assign full  = (sp == DW'(DEPTH));
   assign empty = (sp == '0);
   assign depth = sp;

   // sp is the next free slot, so the top entry lives one below it
   assign wr_ix = IXW'(sp);
   assign rd_ix = IXW'(sp - DW'(1));
   assign top   = mem[rd_ix];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + DW'(1);
      end else if (pop && !empty) begin
         sp <= sp - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ix] <= din;
      end
   end

endmodule

// File: rtl/ir_callstack.sv
// Fetch/decode instruction register: latches PR_code, flags bsr/ret, and
// keeps a hardware return-address stack feeding the PC mux.
module ir_callstack
   import ir_pkg::*;
#(
   parameter int             IW       = IR_IW,
   parameter int             OPW      = IR_OPW,
   parameter int             AW       = IR_AW,
   parameter int             DEPTH    = IR_DEPTH,
   parameter logic [OPW-1:0] BSR_OP   = IR_BSR_OP,
   parameter logic [IW-1:0]  RET_CODE = IR_RET_CODE,
   parameter logic [IW-1:0]  NOP_CODE = IR_NOP_CODE
) (
   input  logic         CLK,
   input  logic         RESET,
   ir_callstack_if.slave bus
);

   localparam int DW = $clog2(DEPTH + 1);

   dec_e          dec;
   logic          advance;
   logic          push;
   logic          pop;
   logic          ovf_evt;
   logic          unf_evt;
   logic [AW-1:0] push_addr;

   logic [AW-1:0] stk_top;
   logic [DW-1:0] stk_depth;
   logic          stk_full;
   logic          stk_empty;

   logic [IW-1:0] ir_q;
   logic          bsr_q;
   logic          ret_q;
   logic [AW-1:0] ra_q;
   logic          ovf_q;
   logic          unf_q;

   // ret is a full-word match and takes priority over the bsr field match
   always_comb begin
      dec = DEC_NONE;
      if (bus.PR_code == RET_CODE) begin
         dec = DEC_RET;
      end else if (bus.PR_code[IW-1:IW-OPW] == BSR_OP) begin
         dec = DEC_BSR;
      end
   end

   assign advance   = !bus.FLUSH && !bus.HOLD;
   assign push      = advance && (dec == DEC_BSR);
   assign pop       = advance && (dec == DEC_RET);
   assign ovf_evt   = push && stk_full;
   assign unf_evt   = pop && stk_empty;
   assign push_addr = bus.PC_in + AW'(1);

   ret_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk   (CLK),
      .rst   (RESET),
      .push  (push),
      .pop   (pop),
      .din   (push_addr),
      .top   (stk_top),
      .depth (stk_depth),
      .full  (stk_full),
      .empty (stk_empty)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ir_q  <= NOP_CODE;
         bsr_q <= 1'b0;
         ret_q <= 1'b0;
         ra_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (bus.FLUSH) begin
         ir_q  <= NOP_CODE;
         bsr_q <= 1'b0;
         ret_q <= 1'b0;
      end else if (!bus.HOLD) begin
         ir_q  <= bus.PR_code;
         bsr_q <= (dec == DEC_BSR);
         ret_q <= (dec == DEC_RET);
         if (dec == DEC_RET) begin
            ra_q <= stk_empty ? '0 : stk_top;
         end
         // a new error event on the same edge outranks the clear
         ovf_q <= ovf_evt || (ovf_q && !bus.clr_err);
         unf_q <= unf_evt || (unf_q && !bus.clr_err);
      end
   end

   assign bus.IR_code     = ir_q;
   assign bus.bsr_det     = bsr_q;
   assign bus.ret_det     = ret_q;
   assign bus.ret_addr    = ra_q;
   assign bus.stack_depth = stk_depth;
   assign bus.stack_full  = stk_full;
   assign bus.stack_empty = stk_empty;
   assign bus.stack_ovf   = ovf_q;
   assign bus.stack_unf   = unf_q;

endmodule

// File: tb/tb_ir_callstack.sv
// Bench for ir_callstack: directed call/return scenarios then random traffic,
// all checked against a queue-based model of the return stack.
module tb_ir_callstack;

   localparam int IW    = 22;
   localparam int AW    = 10;
   localparam int DEPTH = 8;
   localparam logic [11:0] BSR_OP   = 12'b011100000000;
   localparam logic [21:0] RET_CODE = 22'b0000011000000000000000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_err    = 0;

   // model state
   logic [IW-1:0] m_ir;
   logic          m_bsr;
   logic          m_ret;
   logic [AW-1:0] m_ra;
   logic          m_ovf;
   logic          m_unf;
   logic [AW-1:0] exp_q[$];

   ir_callstack_if #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) bus ();

   ir_callstack dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] bsr_word(input logic [AW-1:0] low);
      logic [IW-1:0] w;
      w = {BSR_OP, low};
      return w;
   endfunction

   task automatic model_reset();
      m_ir  = '0;
      m_bsr = 1'b0;
      m_ret = 1'b0;
      m_ra  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_edge();
      logic [IW-1:0] w;
      logic is_ret, is_bsr;
      w = bus.PR_code;
      if (bus.FLUSH) begin
         m_ir  = '0;
         m_bsr = 1'b0;
         m_ret = 1'b0;
      end else if (!bus.HOLD) begin
         is_ret = (w == RET_CODE);
         is_bsr = !is_ret && (w[21:10] == BSR_OP);
         m_ir  = w;
         m_bsr = is_bsr;
         m_ret = is_ret;
         if (bus.clr_err) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (is_bsr) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(AW'((int'(bus.PC_in) + 1) % 1024));
            else m_ovf = 1'b1;
         end
         if (is_ret) begin
            if (exp_q.size() > 0) m_ra = exp_q.pop_back();
            else begin
               m_ra  = '0;
               m_unf = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all(input string pfx);
      check({pfx, ".ir"},    32'(bus.IR_code),     32'(m_ir));
      check({pfx, ".bsr"},   32'(bus.bsr_det),     32'(m_bsr));
      check({pfx, ".ret"},   32'(bus.ret_det),     32'(m_ret));
      check({pfx, ".ra"},    32'(bus.ret_addr),    32'(m_ra));
      check({pfx, ".depth"}, 32'(bus.stack_depth), 32'(exp_q.size()));
      check({pfx, ".full"},  32'(bus.stack_full),  32'(exp_q.size() == DEPTH));
      check({pfx, ".empty"}, 32'(bus.stack_empty), 32'(exp_q.size() == 0));
      check({pfx, ".ovf"},   32'(bus.stack_ovf),   32'(m_ovf));
      check({pfx, ".unf"},   32'(bus.stack_unf),   32'(m_unf));
   endtask

   task automatic step(input string pfx);
      @(posedge clk);
      model_edge();
      #1;
      check_all(pfx);
   endtask

   task automatic drive(input logic [IW-1:0] w, input logic [AW-1:0] pc,
                        input logic hold, input logic flush, input logic clr);
      bus.PR_code = w;
      bus.PC_in   = pc;
      bus.HOLD    = hold;
      bus.FLUSH   = flush;
      bus.clr_err = clr;
   endtask

   // reset asserted mid-cycle must clear outputs before the next edge
   task automatic do_reset(input string pfx);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all({pfx, ".async"});
      repeat (2) @(posedge clk);
      #1;
      check_all({pfx, ".held"});
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      model_reset();

      // reset then idle
      do_reset("reset");
      drive(22'h000123, 10'h000, 1'b0, 1'b0, 1'b0);
      step("idle");
      check("idle.ir_const", 32'(bus.IR_code), 32'h000123);

      // call / return pair
      drive(bsr_word(10'h055), 10'h010, 1'b0, 1'b0, 1'b0);
      step("call");
      check("call.bsr_const", 32'(bus.bsr_det), 32'd1);
      check("call.depth_const", 32'(bus.stack_depth), 32'd1);
      drive(RET_CODE, 10'h000, 1'b0, 1'b0, 1'b0);
      step("return");
      check("return.ra_const", 32'(bus.ret_addr), 32'h011);
      check("return.depth_const", 32'(bus.stack_depth), 32'd0);

      // nesting to overflow, then LIFO unwind
      for (int i = 0; i < 9; i++) begin
         drive(bsr_word(AW'($urandom_range(0, 1023))), AW'(i), 1'b0, 1'b0, 1'b0);
         step("nest");
      end
      check("nest.full_const", 32'(bus.stack_full), 32'd1);
      check("nest.ovf_const", 32'(bus.stack_ovf), 32'd1);
      check("nest.depth_const", 32'(bus.stack_depth), 32'd8);
      for (int i = 0; i < 8; i++) begin
         drive(RET_CODE, AW'($urandom_range(0, 1023)), 1'b0, 1'b0, 1'b0);
         step("unwind");
         check("unwind.ra_const", 32'(bus.ret_addr), 32'(8 - i));
      end
      drive('0, '0, 1'b0, 1'b0, 1'b1);
      step("clr_ovf");

      // underflow and clear
      drive(RET_CODE, '0, 1'b0, 1'b0, 1'b0);
      step("unf");
      check("unf.flag_const", 32'(bus.stack_unf), 32'd1);
      check("unf.ra_const", 32'(bus.ret_addr), 32'd0);
      drive(22'h000777, '0, 1'b0, 1'b0, 1'b1);
      step("unf_clr");
      check("unf_clr.flag_const", 32'(bus.stack_unf), 32'd0);

      // hold, then flush while held
      drive(bsr_word(10'h2AA), 10'h005, 1'b1, 1'b0, 1'b1);
      repeat (3) step("hold");
      check("hold.ir_const", 32'(bus.IR_code), 32'h000777);
      check("hold.depth_const", 32'(bus.stack_depth), 32'd0);
      drive(bsr_word(10'h2AA), 10'h005, 1'b1, 1'b1, 1'b0);
      step("flush");
      check("flush.ir_const", 32'(bus.IR_code), 32'd0);
      check("flush.bsr_const", 32'(bus.bsr_det), 32'd0);

      // address wrap on push
      drive(bsr_word(10'h001), 10'h3FF, 1'b0, 1'b0, 1'b0);
      step("wrap_push");
      drive(RET_CODE, '0, 1'b0, 1'b0, 1'b0);
      step("wrap_pop");
      check("wrap.ra_const", 32'(bus.ret_addr), 32'd0);

      // async reset with live stack contents and flags
      drive(bsr_word(10'h0F0), 10'h123, 1'b0, 1'b0, 1'b0);
      step("pre_rst");
      drive(RET_CODE, '0, 1'b0, 1'b0, 1'b0);
      step("pre_rst");
      step("pre_rst");
      do_reset("midrst");

      // random traffic
      for (int n = 0; n < 600; n++) begin
         int kind;
         logic [IW-1:0] w;
         kind = $urandom_range(0, 9);
         if (kind < 3)      w = bsr_word(AW'($urandom_range(0, 1023)));
         else if (kind < 6) w = RET_CODE;
         else               w = IW'($urandom);
         drive(w, AW'($urandom_range(0, 1023)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 9) == 0));
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
